// File: rtl/gate_bist_pkg.sv
// Shared types for the gate BIST checker: gate opcodes, FSM states and the
// reference truth function used to judge the sampled gate output.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    function automatic logic expected_y(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_bist_seq.sv
// Pattern sequencer for the gate BIST checker: pattern index, remaining-pass
// count and settle timer, all steered by the FSM in the top module.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int REPEAT        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       tick,
    output logic [1:0] idx,
    output logic       settle_tc,
    output logic       last_pat
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LOAD   = PW'(REPEAT - 1);

    logic [SW-1:0] settle_q;
    logic [PW-1:0] pass_q;

    // Both timers count down and finish at zero, so terminal count is a simple compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 2'b00;
            pass_q   <= '0;
            settle_q <= '0;
        end else if (load) begin
            idx      <= 2'b00;
            pass_q   <= PASS_LOAD;
            settle_q <= SETTLE_LOAD;
        end else if (step) begin
            idx      <= idx + 2'd1;
            settle_q <= SETTLE_LOAD;
            if (idx == 2'b11) begin
                pass_q <= pass_q - PW'(1);
            end
        end else if (tick && settle_q != '0) begin
            settle_q <= settle_q - SW'(1);
        end
    end

    assign settle_tc = (settle_q == '0);
    assign last_pat  = (idx == 2'b11) && (pass_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test checker for a 2-input gate primitive: drives all four {a,b}
// patterns, samples y, and reports mismatch count, failing patterns and pass.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; results of the last run held
//   ST_DRIVE  | current {a,b} applied, waiting SETTLE_CYCLES for y to settle
//   ST_SAMPLE | y compared against the reference for the latched op
//   ST_DONE   | one-cycle done pulse, pass valid, gate inputs parked at 0
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int REPEAT        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic             seq_load, seq_step, seq_tick;
    logic [1:0]       idx;
    logic             settle_tc, last_pat;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    gate_bist_seq #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .REPEAT       (REPEAT)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (seq_load),
        .step     (seq_step),
        .tick     (seq_tick),
        .idx      (idx),
        .settle_tc(settle_tc),
        .last_pat (last_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        seq_load = 1'b0;
        seq_step = 1'b0;
        seq_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seq_load = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                seq_tick = 1'b1;
                if (settle_tc) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_pat) begin
                    state_d = ST_DONE;
                end else begin
                    seq_step = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mismatch = (state_q == ST_SAMPLE) && (y != expected_y(op_q, a, b));
    // The counter never wraps, so err_nxt == 0 reliably means "no mismatch this run".
    assign err_nxt  = (mismatch && err_cnt != {ERR_W{1'b1}}) ? err_cnt + ERR_W'(1) : err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= 1'b0;
            b        <= 1'b0;
            op_q     <= OP_AND;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= 4'b0000;
        end else begin
            if (state_q == ST_IDLE && start) begin
                op_q     <= op_e'(op);
                pass     <= 1'b0;
                err_cnt  <= '0;
                fail_vec <= 4'b0000;
                {a, b}   <= 2'b00;
            end
            if (state_q == ST_SAMPLE) begin
                err_cnt <= err_nxt;
                if (mismatch) begin
                    fail_vec[{a, b}] <= 1'b1;
                end
                if (last_pat) begin
                    pass   <= (err_nxt == '0);
                    {a, b} <= 2'b00;
                end else begin
                    {a, b} <= idx + 2'd1;
                end
            end
        end
    end

    assign busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench for gate_bist_checker: directed runs push expected results,
// per-DUT monitors pop and compare on every done pulse.
module tb_gate_bist_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] err0, fv0, fv1;
    logic [1:0] err1;
    int         ymode0 = 0, ymode1 = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int st0 = 0, st1 = 0;

    typedef struct {
        int         lat;
        logic       pass;
        logic [3:0] err;
        logic [3:0] fv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // y models: 0 = correct AND, 1 = stuck at 0, 2 = inverted AND
    assign y0 = (ymode0 == 0) ? (a0 & b0) : (ymode0 == 1) ? 1'b0 : ~(a0 & b0);
    assign y1 = (ymode1 == 0) ? (a1 & b1) : (ymode1 == 1) ? 1'b0 : ~(a1 & b1);

    gate_bist_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );

    gate_bist_checker #(.SETTLE_CYCLES(1), .REPEAT(4), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done0) begin
            if (q0.size() == 0) begin
                n_checks++;
                $display("FAIL dut0_unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_latency", cyc - st0 - 1, e.lat);
                check("dut0_pass", pass0, e.pass);
                check("dut0_err_cnt", err0, e.err);
                check("dut0_fail_vec", fv0, e.fv);
                check("dut0_busy_in_done", busy0, 0);
                check("dut0_ab_in_done", {a0, b0}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL dut1_unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_latency", cyc - st1 - 1, e.lat);
                check("dut1_pass", pass1, e.pass);
                check("dut1_err_cnt", {2'b00, err1}, e.err);
                check("dut1_fail_vec", fv1, e.fv);
            end
        end
    end

    // Leaves the bench at the negedge one cycle after the start edge.
    task automatic run0(input logic [1:0] op, input int ym, input logic push,
                        input int lat, input logic p, input logic [3:0] err, input logic [3:0] fv);
        exp_t e;
        @(negedge clk);
        op0    = op;
        ymode0 = ym;
        start0 = 1'b1;
        st0    = cyc;
        if (push) begin
            e.lat = lat; e.pass = p; e.err = err; e.fv = fv;
            q0.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic drain0(input string name);
        for (int i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
        if (q0.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, q0.size());
            q0.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_ab", {a0, b0}, 0);
        check("reset_pass", pass0, 0);
        check("reset_err", err0, 0);
        check("reset_fv", fv0, 0);
        check("reset_dut1", {busy1, done1, a1, b1, pass1, err1, fv1}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: correct AND, pattern sequence 00,00,01,01,10,10,11,11
        run0(2'b00, 0, 1'b1, 8, 1'b1, 4'd0, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            check("t1_ab_seq", {a0, b0}, (k - 1) / 2);
            check("t1_busy", busy0, 1);
            if (k < 8) @(negedge clk);
        end
        drain0("t1");
        check("t1_pass_hold", pass0, 1);

        // 2: y stuck at 0 fails only pattern 11
        run0(2'b00, 1, 1'b1, 8, 1'b0, 4'd1, 4'b1000);
        drain0("t2");

        // 3: XOR expectation against an AND gate
        run0(2'b10, 0, 1'b1, 8, 1'b0, 4'd3, 4'b1110);
        drain0("t3");

        // 4: saturation with 4 passes and a 2-bit counter
        @(negedge clk);
        op1    = 2'b00;
        ymode1 = 2;
        start1 = 1'b1;
        st1    = cyc;
        e.lat = 32; e.pass = 1'b0; e.err = 4'd3; e.fv = 4'b1111;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) begin
            n_checks++;
            $display("FAIL t4_timeout: got %0d pending results, expected 0", q1.size());
            q1.delete();
        end
        repeat (4) @(negedge clk);
        check("t4_err_hold", err1, 2'd3);

        // 5: start and op changes mid-run are ignored
        run0(2'b00, 0, 1'b1, 8, 1'b1, 4'd0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        op0    = 2'b01;
        @(negedge clk);
        start0 = 1'b0;
        drain0("t5");
        repeat (10) @(negedge clk);

        // 6: reset mid-run aborts with no done, then a normal run
        run0(2'b00, 1, 1'b0, 0, 1'b0, 4'd0, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy0, 0);
        check("t6_ab", {a0, b0}, 0);
        check("t6_err", err0, 0);
        check("t6_pass", pass0, 0);
        check("t6_done", done0, 0);
        repeat (12) @(negedge clk);
        run0(2'b00, 0, 1'b1, 8, 1'b1, 4'd0, 4'b0000);
        drain0("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
